// File: rtl/julia_pkg.sv
// Shared types and frame constants for the Julia renderer datapath.
package julia_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, RELEASE} wb_state_t;

   localparam int NUM_JULIA_DEF    = 16;
   localparam int FRAME_W          = 640;
   localparam int FRAME_H          = 480;
   localparam int FRAME_PIXELS_DEF = FRAME_W * FRAME_H;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
   parameter int N     = 16,
   parameter int PTR_W = 4
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant,
   output logic             valid
);

   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!valid && req[(int'(ptr) + i) % N]) begin
            valid = 1'b1;
            grant = PTR_W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/julia_wb_arbiter.sv
// Write-back arbiter: grants one finished Julia worker at a time, issues its
// Avalon-MM pixel write, pulses release to that worker and counts frame pixels.
module julia_wb_arbiter
   import julia_pkg::*;
#(
   parameter int NUM_JULIA    = NUM_JULIA_DEF,
   parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter int CNT_W        = 19
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [NUM_JULIA-1:0]    done,
   input  logic [NUM_JULIA*32-1:0] cataddresses,
   input  logic [NUM_JULIA*32-1:0] catpixels,
   output logic [NUM_JULIA-1:0]    release_oh,
   output logic                    avm_write,
   output logic [31:0]             avm_address,
   output logic [31:0]             avm_writedata,
   input  logic                    avm_waitrequest,
   output logic                    busy,
   output logic [CNT_W-1:0]        pixel_count,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1;

   wb_state_t            state, state_nxt;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     grant_q;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_vld;
   logic                 last_grant_valid;
   logic [NUM_JULIA-1:0] grant_oh;
   logic [NUM_JULIA-1:0] block_mask;
   logic [NUM_JULIA-1:0] req;
   logic                 last_pixel;

   // The just-released worker may still show a stale done for one cycle.
   assign grant_oh   = NUM_JULIA'(1) << grant_q;
   assign block_mask = last_grant_valid ? grant_oh : '0;
   assign req        = done & ~block_mask;
   assign last_pixel = (pixel_count == CNT_W'(FRAME_PIXELS - 1));

   rr_pick #(
      .N     (NUM_JULIA),
      .PTR_W (IDX_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick_idx),
      .valid (pick_vld)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      avm_write  = 1'b0;
      release_oh = '0;
      frame_done = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (enable && pick_vld) state_nxt = WRITE;
         end
         WRITE: begin
            avm_write = 1'b1;
            if (!avm_waitrequest) state_nxt = RELEASE;
         end
         RELEASE: begin
            release_oh = grant_oh;
            frame_done = last_pixel;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address/data are captured at grant so the bus stays stable through stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr           <= '0;
         grant_q          <= '0;
         last_grant_valid <= 1'b0;
         pixel_count      <= '0;
         avm_address      <= '0;
         avm_writedata    <= '0;
      end else begin
         last_grant_valid <= (state == RELEASE);
         if (state == IDLE && state_nxt == WRITE) begin
            grant_q       <= pick_idx;
            avm_address   <= cataddresses[{pick_idx, 5'b0} +: 32];
            avm_writedata <= catpixels[{pick_idx, 5'b0} +: 32];
         end
         if (state == RELEASE) begin
            rr_ptr      <= (grant_q == IDX_W'(NUM_JULIA - 1)) ? '0 : grant_q + IDX_W'(1);
            pixel_count <= last_pixel ? '0 : pixel_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_julia_wb_arbiter.sv
// Scoreboard bench for julia_wb_arbiter: stimulus queues expected writes,
// a monitor pops them on every release pulse.
module tb_julia_wb_arbiter;

   localparam int N  = 16;
   localparam int FP = 4;
   localparam int CW = 19;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [N-1:0]    done;
   logic [N*32-1:0] cataddresses;
   logic [N*32-1:0] catpixels;
   logic [N-1:0]    release_oh;
   logic            avm_write;
   logic [31:0]     avm_address;
   logic [31:0]     avm_writedata;
   logic            avm_waitrequest;
   logic            busy;
   logic [CW-1:0]   pixel_count;
   logic            frame_done;

   julia_wb_arbiter #(
      .NUM_JULIA    (N),
      .FRAME_PIXELS (FP),
      .CNT_W        (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .done            (done),
      .cataddresses    (cataddresses),
      .catpixels       (catpixels),
      .release_oh      (release_oh),
      .avm_write       (avm_write),
      .avm_address     (avm_address),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .pixel_count     (pixel_count),
      .frame_done      (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  rel;
      logic [31:0]   addr;
      logic [31:0]   data;
      logic          fdone;
      logic [CW-1:0] pcnt;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_pcnt = 0;
   logic [31:0] w_addr[N];
   logic [31:0] w_pix[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no DUT event, want one within budget", name);
   endtask

   task automatic update_cat();
      for (int k = 0; k < N; k++) begin
         cataddresses[k*32 +: 32] = w_addr[k];
         catpixels[k*32 +: 32]    = w_pix[k];
      end
   endtask

   task automatic expect_write(input int k);
      exp_t e;
      e.rel   = N'(1) << k;
      e.addr  = w_addr[k];
      e.data  = w_pix[k];
      e.fdone = (exp_pcnt == FP - 1);
      e.pcnt  = CW'(exp_pcnt);
      sb.push_back(e);
      exp_pcnt = (exp_pcnt + 1) % FP;
   endtask

   task automatic wait_release(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (release_oh == '0 && cyc < 64);
      if (release_oh == '0) timeout_fail("release_timeout");
   endtask

   task automatic reset_dut();
      @(negedge clk);
      done = '0;
      rst  = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      exp_pcnt = 0;
   endtask

   // One isolated write; done stays high through the cycle after release.
   task automatic do_single(input int k);
      expect_write(k);
      done = N'(1) << k;
      @(negedge clk);
      check("single_write", {63'd0, avm_write}, 64'd1);
      check("single_addr", {32'd0, avm_address}, {32'd0, w_addr[k]});
      check("single_data", {32'd0, avm_writedata}, {32'd0, w_pix[k]});
      @(negedge clk);
      check("single_release", {48'd0, release_oh}, 64'd1 << k);
      @(negedge clk);
      check("single_pixel_count", {45'd0, pixel_count}, 64'(exp_pcnt));
      check("single_idle", {63'd0, avm_write}, 64'd0);
      @(negedge clk);
      check("no_stale_regrant", {63'd0, avm_write}, 64'd0);
      done = '0;
   endtask

   // Monitor: tracks the bus during writes and scores every release pulse.
   initial begin
      logic [31:0] last_addr;
      logic [31:0] last_data;
      logic        in_write;
      exp_t        e;
      in_write  = 1'b0;
      last_addr = '0;
      last_data = '0;
      forever begin
         @(negedge clk);
         if (avm_write) begin
            if (in_write) begin
               check("hold_addr", {32'd0, avm_address}, {32'd0, last_addr});
               check("hold_data", {32'd0, avm_writedata}, {32'd0, last_data});
            end
            last_addr = avm_address;
            last_data = avm_writedata;
            in_write  = 1'b1;
         end else begin
            in_write = 1'b0;
         end
         if (release_oh != '0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_release: got 0x%0h, want none", release_oh);
            end else begin
               e = sb.pop_front();
               check("release", {48'd0, release_oh}, {48'd0, e.rel});
               check("wr_addr", {32'd0, last_addr}, {32'd0, e.addr});
               check("wr_data", {32'd0, last_data}, {32'd0, e.data});
               check("frame_done", {63'd0, frame_done}, {63'd0, e.fdone});
               check("count_at_release", {45'd0, pixel_count}, {45'd0, e.pcnt});
            end
         end else if (frame_done) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_done: got 1, want 0 without release");
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no end of test, want finish before 50000");
      $fatal(1);
   end

   initial begin
      int cyc;
      int wcnt;
      rst             = 1'b1;
      enable          = 1'b1;
      done            = '1;
      avm_waitrequest = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_addr[k] = 32'h0001_0000 + 32'(k) * 32'h40;
         w_pix[k]  = 32'hC0DE_0000 | 32'(k);
      end
      w_addr[5] = 32'h0000_1234;
      w_pix[5]  = 32'h00FF_00FF;
      update_cat();

      // Reset with every worker requesting.
      @(posedge clk);
      repeat (2) begin
         @(negedge clk);
         check("rst_write", {63'd0, avm_write}, 64'd0);
         check("rst_release", {48'd0, release_oh}, 64'd0);
         check("rst_count", {45'd0, pixel_count}, 64'd0);
         check("rst_busy", {63'd0, busy}, 64'd0);
         check("rst_frame_done", {63'd0, frame_done}, 64'd0);
      end
      rst  = 1'b0;
      done = 16'h0001;
      expect_write(0);
      @(negedge clk);
      check("first_write_after_rst", {63'd0, avm_write}, 64'd1);
      wait_release(cyc);
      done = '0;

      // Single worker 5.
      reset_dut();
      do_single(5);

      // Grants are held off while enable is low.
      enable = 1'b0;
      done   = 16'h0002;
      repeat (3) begin
         @(negedge clk);
         check("disabled_idle", {62'd0, busy, avm_write}, 64'd0);
      end
      enable = 1'b1;
      do_single(1);

      // Round-robin over all workers held requesting.
      reset_dut();
      for (int i = 0; i < 17; i++) expect_write(i % N);
      done = '1;
      for (int i = 0; i < 17; i++) begin
         wait_release(cyc);
         check("rr_spacing", 64'(cyc), (i == 0) ? 64'd2 : 64'd3);
      end
      @(negedge clk);
      done = '0;
      check("rr_count_wrapped", {45'd0, pixel_count}, 64'd1);

      // Waitrequest stall on worker 3 with pixel input changing mid-stall.
      @(negedge clk);
      expect_write(3);
      avm_waitrequest = 1'b1;
      done            = 16'h0008;
      wcnt            = 0;
      cyc             = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (avm_write) wcnt++;
         if (avm_write && wcnt == 2) begin
            w_pix[3] = 32'hDEAD_BEEF;
            update_cat();
         end
         if (wcnt == 3) enable = 1'b0;
         if (wcnt == 6) avm_waitrequest = 1'b0;
      end while (release_oh == '0 && cyc < 40);
      if (release_oh == '0) timeout_fail("stall_release_timeout");
      check("stall_write_cycles", 64'(wcnt), 64'd6);
      repeat (3) begin
         @(negedge clk);
         check("hold_while_disabled", {63'd0, avm_write}, 64'd0);
      end
      done     = '0;
      enable   = 1'b1;
      w_pix[3] = 32'hC0DE_0003;
      update_cat();

      // Frame wrap: four writes from a fresh count.
      reset_dut();
      for (int i = 0; i < 4; i++) do_single(2);
      check("frame_wrap_count", {45'd0, pixel_count}, 64'd0);

      // Reset during a stalled write of worker 7.
      do_single(4);
      avm_waitrequest = 1'b1;
      done            = 16'h0080;
      cyc             = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!avm_write && cyc < 10);
      if (!avm_write) timeout_fail("mid_rst_write_timeout");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_write", {63'd0, avm_write}, 64'd0);
      check("mid_rst_release", {48'd0, release_oh}, 64'd0);
      check("mid_rst_count", {45'd0, pixel_count}, 64'd0);
      check("mid_rst_ptr", 64'(dut.rr_ptr), 64'd0);
      rst             = 1'b0;
      avm_waitrequest = 1'b0;
      exp_pcnt        = 0;
      expect_write(7);
      @(negedge clk);
      check("rearb_write", {63'd0, avm_write}, 64'd1);
      check("rearb_addr", {32'd0, avm_address}, {32'd0, w_addr[7]});
      wait_release(cyc);
      done = '0;

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/julia_wb_arbiter.md
Name: julia_wb_arbiter

Overview:
Write-back arbiter between the NUM_JULIA Julia workers and the pixel frame-buffer memory. It grants one done worker at a time using rotating priority and latches that worker's pixel and address. It issues one Avalon-MM write with waitrequest, then pulses a one-cycle release to the granted worker so the worker can start its next pixel. It counts written pixels and flags frame completion.

Parameters:
NUM_JULIA, 16, number of Julia workers / request lines
FRAME_PIXELS, 307200, pixels per frame (640x480); frame_done fires when this many writes complete
CNT_W, 19, width of pixel counter (>= clog2(FRAME_PIXELS))

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
enable  in  1  permits new grants; in-flight transaction always completes
done  in  NUM_JULIA  per-worker "result ready", level, held until released
cataddresses  in  NUM_JULIA*32  concatenated worker addresses, worker k at [k*32 +: 32]
catpixels  in  NUM_JULIA*32  concatenated worker pixel data, same packing
release  out  NUM_JULIA  one-hot, one-cycle pulse to granted worker after its write is accepted
avm_write  out  1  Avalon write request
avm_address  out  32  write address, held stable while avm_write
avm_writedata  out  32  write data, held stable while avm_write
avm_waitrequest  in  1  slave stall; the write is accepted on a cycle with avm_write=1 and waitrequest=0
busy  out  1  high in any state other than IDLE
pixel_count  out  CNT_W  pixels written in the current frame
frame_done  out  1  one-cycle pulse on the last pixel of a frame

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, rr_ptr=0, last_grant_valid=0, pixel_count=0. All outputs 0 from the following cycle.
- Reset in the middle of a WRITE drops avm_write at that edge. No release pulse is issued. The worker keeps done high and is re-arbitrated after reset.
- FSM states: IDLE, WRITE, RELEASE.
- IDLE:
  - req = done & ~block_mask. block_mask is one-hot of the last-released worker, valid only in the first IDLE cycle after RELEASE. Otherwise block_mask=0.
  - If enable=1 and req!=0: grant = first set bit of req searching upward from rr_ptr, wrapping modulo NUM_JULIA.
  - Capture cataddresses/catpixels slice [grant*32 +: 32] into avm_address/avm_writedata. Register grant. Go to WRITE.
- WRITE:
  - avm_write=1. Address and data are frozen and unaffected by input changes.
  - If avm_waitrequest=0 this cycle: go to RELEASE. Otherwise stay in WRITE, with no timeout.
- RELEASE (exactly 1 cycle):
  - release[grant]=1, avm_write=0.
  - rr_ptr <= (grant+1) mod NUM_JULIA.
  - If pixel_count==FRAME_PIXELS-1: pixel_count <= 0 and frame_done=1 this cycle. Otherwise pixel_count increments.
  - Go to IDLE.
- Latency: done rising in IDLE cycle t gives avm_write=1 at t+1. With zero wait states the release pulse is at t+2. Minimum 3 cycles per pixel.
- Fairness: with all workers continuously done, grants rotate 0,1,...,N-1,0. No worker waits more than NUM_JULIA grants.
- Workers must drop done by the cycle after release. block_mask covers that one-cycle lag so the same worker is not re-granted on a stale done.
- enable=0 during WRITE/RELEASE: the transaction finishes normally, then the FSM holds in IDLE.
- done deasserting during WRITE is ignored, because the data was captured at grant.
- pixel_count wraps only through the frame_done path. It never exceeds FRAME_PIXELS-1.

Decomposition:
- Package julia_pkg: state enum wb_state_t {IDLE, WRITE, RELEASE}, constants NUM_JULIA_DEF=16, FRAME_W=640, FRAME_H=480, FRAME_PIXELS_DEF.
- Sub-module rr_pick: combinational rotating-priority picker. Inputs req[NUM_JULIA], ptr. Outputs grant index and valid. Reusable by the dispatch side.

Test Plan:
- Reset/idle: rst high 2 cycles with done=16'hFFFF. Required: avm_write=0, release=0, pixel_count=0 throughout; first avm_write appears the cycle after rst falls.
- Single worker: done=16'h0020, worker 5 address 0x0000_1234, pixel 0x00FF_00FF, waitrequest=0. Required: avm_write at t+1 with address 0x1234 and data 0x00FF00FF; release=16'h0020 at t+2; pixel_count=1.
- Round-robin: all done held high and re-raised 1 cycle after each release. Required: grant order 0,1,...,15,0 over 17 writes, 3 cycles each.
- Waitrequest stall: waitrequest high 5 cycles during a write to worker 3; change catpixels mid-stall. Required: avm_write high 6 cycles; address and data equal the captured values; release=16'h0008 once, after acceptance.
- Frame wrap: FRAME_PIXELS=4, 4 writes. Required: frame_done pulses exactly with the 4th release; pixel_count returns to 0.
- Mid-write reset: rst asserted during stalled WRITE of worker 7. Required: avm_write 0 next cycle, no release pulse, rr_ptr=0, pixel_count=0; worker 7 is granted again after reset.
